// File: rtl/mont_redu_word_pipe_pkg.sv
//==============================================================================
// Module      : mont_pkg
// Description : Shared defaults, widths, stage record and helpers for the
//               word-serial Montgomery reducer.
//               Contents:
//                 DEF_QW / DEF_WW / DEF_NSTG : default modulus width, word
//                                              width and stage count
//                 TW / QHW / KW              : product, modulus-high and
//                                              k-field widths for the defaults
//                 kw_of()                    : k-field width for a stage count
//                 stage_t                    : stage record for the defaults
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mont_pkg;

    localparam int DEF_QW   = 32;
    localparam int DEF_WW   = 8;
    localparam int DEF_NSTG = 4;

    // Width of the per-sample iteration field; at least one bit so that a
    // single-stage build still has a port.
    function automatic int kw_of(input int nstg);
        return (nstg < 2) ? 1 : $clog2(nstg);
    endfunction

    localparam int TW  = 2 * DEF_QW;
    localparam int QHW = DEF_QW - DEF_WW;
    localparam int KW  = kw_of(DEF_NSTG);

    // Contents of one pipeline stage in the default configuration.
    typedef struct packed {
        logic           valid;
        logic [TW-1:0]  t;
        logic [QHW-1:0] qh;
        logic [KW-1:0]  k;
        logic           done;
    } stage_t;

endpackage

`default_nettype wire

// File: rtl/mont_redu_word_pipe_step.sv
//==============================================================================
// Module      : mont_word_step
// Description : One word-serial Montgomery iteration plus its stage register.
//               For a sample that has not finished:
//                 TL = T[WW-1:0], TC = -TL mod 2^WW
//                 T' = qh*TC + (T >> WW) + (TL != 0)
//               which equals (T + q*TC) / 2^WW for q = qh*2^WW + 1.
//               Finished samples pass through untouched.
// Ports       : clk, rst           clock / async active-high reset
//               en_i               stage advance enable
//               valid_i..done_i    incoming stage record
//               valid_o..done_o    registered stage record
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mont_word_step
    import mont_pkg::*;
#(
    parameter int QW  = DEF_QW,
    parameter int WW  = DEF_WW,
    parameter int KW  = 2,
    parameter int STG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic [2*QW-1:0]   t_i,
    input  logic [QW-WW-1:0]  qh_i,
    input  logic [KW-1:0]     k_i,
    input  logic              done_i,
    output logic              valid_o,
    output logic [2*QW-1:0]   t_o,
    output logic [QW-WW-1:0]  qh_o,
    output logic [KW-1:0]     k_o,
    output logic              done_o
);

    localparam int            TW_W  = 2 * QW;
    localparam logic [KW-1:0] STG_K = KW'(STG);

    logic [WW-1:0]   w_tl;
    logic [WW-1:0]   w_tc;
    logic            w_carry;
    logic [QW-1:0]   w_prod;
    logic [TW_W-1:0] w_t_red;
    logic [TW_W-1:0] t_d;
    logic            done_d;

    logic            valid_q;
    logic [TW_W-1:0] t_q;
    logic [QW-WW-1:0] qh_q;
    logic [KW-1:0]   k_q;
    logic            done_q;

    assign w_tl    = t_i[WW-1:0];
    assign w_tc    = (~w_tl) + WW'(1);
    // (T + TC) >> WW without a wide adder: the low word sums to exactly 2^WW
    // when TL is nonzero, contributing a single carry into the upper part.
    assign w_carry = |w_tl;
    assign w_prod  = QW'(qh_i) * QW'(w_tc);
    assign w_t_red = TW_W'(w_prod) + (t_i >> WW) + TW_W'(w_carry);

    assign t_d     = done_i ? t_i : w_t_red;
    // Stage STG performs iteration number STG; after it, a sample asking for
    // k+1 iterations with k == STG is complete.
    assign done_d  = done_i | (k_i == STG_K);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            t_q     <= '0;
            qh_q    <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            t_q     <= t_d;
            qh_q    <= qh_i;
            k_q     <= k_i;
            done_q  <= done_d;
        end
    end

    assign valid_o = valid_q;
    assign t_o     = t_q;
    assign qh_o    = qh_q;
    assign k_o     = k_q;
    assign done_o  = done_q;

endmodule

`default_nettype wire

// File: rtl/mont_redu_word_pipe.sv
//==============================================================================
// Module      : mont_redu_word_pipe
// Description : Parametrised word-serial Montgomery reducer.
//               res = c_in * 2^(-WW*(k_in+1)) mod q_in, for q_in = qh*2^WW + 1.
//               NSTG reduction stages plus one output stage; fixed latency of
//               NSTG+1 accepted cycles regardless of k, so order is preserved.
//               One global enable stalls every stage together.
// Ports       : clk        clock
//               reset      asynchronous active-high reset
//               in_valid   input sample valid
//               in_ready   sample can be accepted this cycle
//               c_in       2*QW-bit product to reduce
//               q_in       QW-bit modulus (low WW bits must be 1)
//               k_in       iteration count minus one (clamped to NSTG-1)
//               out_valid  result valid
//               out_ready  downstream accepts result
//               res        reduced result
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mont_redu_word_pipe
    import mont_pkg::*;
#(
    parameter int QW        = DEF_QW,
    parameter int WW        = DEF_WW,
    parameter int NSTG      = DEF_NSTG,
    parameter int FINAL_SUB = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*QW-1:0]           c_in,
    input  logic [QW-1:0]             q_in,
    input  logic [kw_of(NSTG)-1:0]    k_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QW-1:0]             res
);

    localparam int             TW_W = 2 * QW;
    localparam int             QH_W = QW - WW;
    localparam int             K_W  = kw_of(NSTG);
    localparam logic [K_W-1:0] KMAX = K_W'(NSTG - 1);

    // Index 0 is the incoming sample, index j+1 the register of stage j.
    logic            w_stg_valid [0:NSTG];
    logic [TW_W-1:0] w_stg_t     [0:NSTG];
    logic [QH_W-1:0] w_stg_qh    [0:NSTG];
    logic [K_W-1:0]  w_stg_k     [0:NSTG];
    logic            w_stg_done  [0:NSTG];

    logic            w_en;
    logic [K_W-1:0]  w_k_clamp;
    logic [TW_W-1:0] w_t_last;
    logic [QW-1:0]   w_q_last;
    logic            w_ge_q;
    logic [QW-1:0]   res_d;
    logic            w_unused;

    logic            out_valid_q;
    logic [QW-1:0]   res_q;

    // Pipeline may move whenever the output register is empty or draining.
    assign w_en     = out_ready | ~out_valid_q;
    assign in_ready = w_en;

    // Only a non-power-of-two stage count can present out-of-range k codes.
    generate
        if ((1 << K_W) == NSTG) begin : g_kpass
            assign w_k_clamp = k_in;
        end else begin : g_kclamp
            assign w_k_clamp = (k_in > KMAX) ? KMAX : k_in;
        end
    endgenerate

    // An idle input cycle enters as a bubble (valid=0).
    assign w_stg_valid[0] = in_valid;
    assign w_stg_t[0]     = c_in;
    assign w_stg_qh[0]    = q_in[QW-1:WW];
    assign w_stg_k[0]     = w_k_clamp;
    assign w_stg_done[0]  = 1'b0;

    generate
        for (genvar j = 0; j < NSTG; j++) begin : g_stage
            mont_word_step #(
                .QW  (QW),
                .WW  (WW),
                .KW  (K_W),
                .STG (j)
            ) u_step (
                .clk     (clk),
                .rst     (reset),
                .en_i    (w_en),
                .valid_i (w_stg_valid[j]),
                .t_i     (w_stg_t[j]),
                .qh_i    (w_stg_qh[j]),
                .k_i     (w_stg_k[j]),
                .done_i  (w_stg_done[j]),
                .valid_o (w_stg_valid[j+1]),
                .t_o     (w_stg_t[j+1]),
                .qh_o    (w_stg_qh[j+1]),
                .k_o     (w_stg_k[j+1]),
                .done_o  (w_stg_done[j+1])
            );
        end
    endgenerate

    // Rebuild the modulus; its low word is 1 by construction.
    assign w_t_last = w_stg_t[NSTG];
    assign w_q_last = {w_stg_qh[NSTG], WW'(1)};
    assign w_ge_q   = (w_t_last >= TW_W'(w_q_last));

    // The raw result is below 2q for in-range inputs, so one conditional
    // subtraction lands in [0,q); the difference fits in QW bits.
    always_comb begin
        res_d = w_t_last[QW-1:0];
        if ((FINAL_SUB != 0) && w_ge_q) begin
            res_d = w_t_last[QW-1:0] - w_q_last;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (w_en) begin
            out_valid_q <= w_stg_valid[NSTG];
            // Keep the last result visible across bubbles.
            if (w_stg_valid[NSTG]) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;

    // The modulus low word is implied, and the final stage's bookkeeping
    // fields have no consumer.
    assign w_unused = ^{q_in[WW-1:0], w_stg_k[NSTG], w_stg_done[NSTG]};

endmodule

`default_nettype wire

// File: tb/tb_mont_redu_word_pipe.sv
//==============================================================================
// Module      : tb_mont_redu_word_pipe
// Description : Scoreboard bench for mont_redu_word_pipe. Two instances share
//               all inputs: one with the final subtraction, one raw. Expected
//               values come from a whole-number Montgomery model:
//                 m   = -c * q^-1 mod R,  R = 2^(8(k+1))
//                 raw = (c + q*m) / R,    res = raw mod q (raw < 2q)
//               and each result is also checked for res*R == c (mod q).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mont_redu_word_pipe;

    localparam int NSTG = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready_raw;
    logic [63:0] c_in;
    logic [31:0] q_in;
    logic [1:0]  k_in;
    logic        out_valid;
    logic        out_valid_raw;
    logic        out_ready;
    logic [31:0] res;
    logic [31:0] res_raw;

    typedef struct {
        logic [63:0] c;
        logic [31:0] q;
        int          k;
        logic [31:0] exp;
        logic [31:0] exp_raw;
    } sb_t;

    sb_t sb[$];

    int n_chk   = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int stall_from  = 0;
    int stall_until = 0;
    bit rnd_ready   = 0;

    mont_redu_word_pipe #(.QW(32), .WW(8), .NSTG(NSTG), .FINAL_SUB(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .c_in(c_in), .q_in(q_in), .k_in(k_in), .out_valid(out_valid),
        .out_ready(out_ready), .res(res)
    );

    mont_redu_word_pipe #(.QW(32), .WW(8), .NSTG(NSTG), .FINAL_SUB(0)) dut_raw (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_raw),
        .c_in(c_in), .q_in(q_in), .k_in(k_in), .out_valid(out_valid_raw),
        .out_ready(out_ready), .res(res_raw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Downstream acceptance: forced low inside a stall window, else random or 1.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (cyc >= stall_from && cyc < stall_until) out_ready = 1'b0;
            else if (rnd_ready) out_ready = ($urandom_range(0, 4) != 0);
            else out_ready = 1'b1;
        end
    end

    // ---------------------------------------------------------------- model
    function automatic logic [127:0] raw_model(input logic [63:0] c, input logic [31:0] q, input int k);
        logic [127:0] r, msk, x, m, c128, q128, m64;
        int sh;
        sh   = 8 * (k + 1);
        r    = 128'd1 << sh;
        msk  = r - 128'd1;
        m64  = (128'd1 << 64) - 128'd1;
        c128 = {64'd0, c};
        q128 = {96'd0, q};
        // q == 1 mod 256, so 1 is its inverse mod 2^8; Newton lifts to 2^64.
        x = 128'd1;
        for (int i = 0; i < 6; i++) begin
            x = (x * ((128'd2 - ((q128 * x) & m64)) & m64)) & m64;
        end
        m = ((((r - (c128 & msk)) & msk) * (x & msk)) & msk);
        return (c128 + q128 * m) >> sh;
    endfunction

    // ---------------------------------------------------------------- stimulus
    task automatic send(input logic [63:0] c, input logic [31:0] q, input int k,
                        input bit has_exp, input logic [31:0] exp_c);
        logic [127:0] raw;
        sb_t e;
        bit acc;
        bit sent;
        in_valid = 1'b1;
        c_in     = c;
        q_in     = q;
        k_in     = 2'(k);
        sent     = 0;
        for (int t = 0; t < 1000 && !sent; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                raw       = raw_model(c, q, k);
                e.c       = c;
                e.q       = q;
                e.k       = k;
                e.exp_raw = raw[31:0];
                e.exp     = has_exp ? exp_c :
                            ((raw >= {96'd0, q}) ? 32'(raw - {96'd0, q}) : raw[31:0]);
                sb.push_back(e);
                sent = 1;
            end
            #1;
        end
        if (!sent) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        c_in     = {$urandom, $urandom};
        q_in     = $urandom;
        k_in     = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand(input logic [31:0] q, input int k);
        logic [127:0] lim, c;
        lim = {96'd0, q} << (8 * (k + 1));
        c   = {64'd0, $urandom, $urandom} % lim;
        send(c[63:0], q, k, 0, 32'd0);
    endtask

    function automatic logic [31:0] rand_q();
        return {24'($urandom_range(1, 24'hFF_FFFF)), 8'h01};
    endfunction

    task automatic drain();
        int t;
        in_valid = 1'b0;
        for (t = 0; t < 400 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
    endtask

    // ---------------------------------------------------------------- monitor
    bit          held_v = 0;
    logic [31:0] held_res;
    logic [31:0] held_raw;

    always @(negedge clk) begin
        if (reset) begin
            held_v = 0;
        end else begin
            n_chk++;
            if (in_ready !== (out_ready | ~out_valid)) begin
                n_fail++;
                $display("FAIL in_ready: got %0b, required %0b", in_ready, out_ready | ~out_valid);
            end
            n_chk++;
            if (out_valid_raw !== out_valid) begin
                n_fail++;
                $display("FAIL valid_lockstep: raw out_valid %0b, required %0b", out_valid_raw, out_valid);
            end
            if (held_v) begin
                n_chk++;
                if (out_valid !== 1'b1 || res !== held_res || res_raw !== held_raw) begin
                    n_fail++;
                    $display("FAIL hold: out_valid=%0b res=%0d raw=%0d, required 1 %0d %0d",
                             out_valid, res, res_raw, held_res, held_raw);
                end
            end
            held_v   = out_valid && !out_ready;
            held_res = res;
            held_raw = res_raw;
            if (out_valid && out_ready) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: res=%0d, required no output", res);
                end else begin
                    sb_t e;
                    logic [127:0] lhs, rhs;
                    e = sb.pop_front();
                    if (res !== e.exp) begin
                        n_fail++;
                        $display("FAIL res: c=%0d q=%0d k=%0d got %0d, required %0d", e.c, e.q, e.k, res, e.exp);
                    end
                    n_chk++;
                    if (res_raw !== e.exp_raw) begin
                        n_fail++;
                        $display("FAIL res_raw: c=%0d q=%0d k=%0d got %0d, required %0d", e.c, e.q, e.k, res_raw, e.exp_raw);
                    end
                    n_chk++;
                    lhs = (({96'd0, res}) << (8 * (e.k + 1))) % {96'd0, e.q};
                    rhs = {64'd0, e.c} % {96'd0, e.q};
                    if (res >= e.q || lhs != rhs) begin
                        n_fail++;
                        $display("FAIL congruence: res=%0d q=%0d res*R mod q=%0d, required < q and %0d", res, e.q, lhs, rhs);
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- main
    initial begin
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        c_in     = '0;
        q_in     = '0;
        k_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_valid_raw !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %0b/%0b, required 0", out_valid, out_valid_raw);
        end
        n_chk++;
        if (res !== 32'd0 || res_raw !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_res: got %0d/%0d, required 0", res, res_raw);
        end
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
        @(posedge clk);
        #1;

        // Directed values with q = 7681.
        send(64'd1,       32'd7681, 0, 1, 32'd7651);
        send(64'd1,       32'd7681, 1, 1, 32'd900);
        send(64'd256,     32'd7681, 0, 1, 32'd1);
        send(64'd0,       32'd7681, 3, 1, 32'd0);
        send(64'd1966336, 32'd7681, 0, 1, 32'd0);
        idle();
        drain();

        // Back-to-back mixed-k stream with a 3-cycle downstream stall.
        stall_from  = cyc + 7;
        stall_until = cyc + 10;
        for (int i = 0; i < 20; i++) begin
            case (i % 3)
                0:       send_rand(32'd7681, i % 4);
                1:       send_rand(32'd12289, (i + 1) % 4);
                default: send_rand(rand_q(), $urandom_range(0, 3));
            endcase
        end
        drain();

        // Reset with samples in flight: output held full, four more behind it.
        stall_from  = 0;
        stall_until = 32'h7FFF_FFFF;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send_rand(rand_q(), i % 4);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_valid_raw !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_valid: got %0b/%0b, required 0", out_valid, out_valid_raw);
        end
        stall_until = 0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Latency of the first sample after reset.
        send_rand(32'd7681, 2);
        in_valid = 1'b0;
        n = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            n++;
        end
        #1;
        n_chk++;
        if (n != NSTG + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, required %0d", n, NSTG + 1);
        end
        @(posedge clk);
        #1;
        drain();

        // Random stream with random gaps and random back-pressure.
        rnd_ready = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 9) == 0) idle();
            send_rand(rand_q(), $urandom_range(0, 3));
        end
        rnd_ready = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
